// File: rtl/cnn_mem_pkg.sv
// Shared constants, word/block types and the store FSM state encoding
// for the CNN memory mover blocks.
package cnn_mem_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int BLOCK     = 25;
    localparam int BUF_DEPTH = 1024;

    localparam int RD_W    = $clog2(BUF_DEPTH);
    localparam int WORDS_W = RD_W + 1;
    localparam int SLOT_W  = $clog2(BLOCK);
    localparam int CNT_W   = $clog2(BLOCK + 1);

    typedef logic signed [DATA_W-1:0] word_t;
    typedef word_t [BLOCK-1:0] block_t;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

endpackage

// File: rtl/block_packer.sv
// BLOCK-slot pack register: clears between bursts, captures one word per
// write into an indexed slot, and derives the valid-word mask from a count.
module block_packer
    import cnn_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] slot,
    input  word_t             wr_data,
    input  logic [CNT_W-1:0]  count,
    output block_t            data,
    output logic [BLOCK-1:0]  mask
);

    // Clearing before each burst leaves unwritten tail slots at zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            data <= '0;
        end else if (wr_en) begin
            data[slot] <= wr_data;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < BLOCK; i++) begin
            mask[i] = (CNT_W'(i) < count);
        end
    end

endmodule

// File: rtl/store_block.sv
// Write-back mover: reads a size x size map from the local buffer and
// emits it to the DMA write port as BLOCK-word bursts.
module store_block
    import cnn_mem_pkg::*;
#(
    parameter int SIZE_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SIZE_W-1:0]       size,
    input  logic [ADDR_W-1:0]       base_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    src_rd_en,
    output logic [RD_W-1:0]         src_rd_addr,
    input  logic [DATA_W-1:0]       src_rd_data,
    output logic                    dma_wr_valid,
    input  logic                    dma_wr_ready,
    output logic [ADDR_W-1:0]       dma_wr_addr,
    output logic [BLOCK*DATA_W-1:0] dma_wr_data,
    output logic [BLOCK-1:0]        dma_wr_mask
);

    state_t              state, next_state;
    logic [WORDS_W-1:0]  words_q, rem;
    logic [CNT_W-1:0]    rd_cnt;
    logic [RD_W-1:0]     rd_idx;
    logic                cap_valid;
    logic [SLOT_W-1:0]   cap_slot;
    logic [ADDR_W-1:0]   burst_addr;

    logic [2*SIZE_W-1:0] prod;
    logic [WORDS_W-1:0]  words_in;
    logic [CNT_W-1:0]    burst_n;
    logic                accept, rd_fire, handshake, last_cap;
    block_t              pack_data;

    assign prod     = {{SIZE_W{1'b0}}, size} * {{SIZE_W{1'b0}}, size};
    assign words_in = (prod > (2*SIZE_W)'(BUF_DEPTH)) ? WORDS_W'(BUF_DEPTH)
                                                       : prod[WORDS_W-1:0];

    // Words in the current burst: a full block unless only a tail remains.
    assign burst_n   = (rem >= WORDS_W'(BLOCK)) ? CNT_W'(BLOCK) : CNT_W'(rem);
    assign accept    = (state == IDLE) && start;
    assign rd_fire   = (state == FETCH) && (rd_cnt < burst_n);
    assign handshake = (state == WRITE) && dma_wr_ready;
    assign last_cap  = cap_valid && (cap_slot == SLOT_W'(burst_n - CNT_W'(1)));

    assign busy         = (state == FETCH) || (state == WRITE);
    assign done         = (state == DONE);
    assign src_rd_en    = rd_fire;
    assign src_rd_addr  = rd_idx;
    assign dma_wr_valid = (state == WRITE);
    assign dma_wr_addr  = burst_addr;
    assign dma_wr_data  = pack_data;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = FETCH;
            FETCH: begin
                if (words_q == '0)  next_state = DONE;
                else if (last_cap)  next_state = WRITE;
            end
            WRITE: begin
                if (handshake)
                    next_state = (rem <= WORDS_W'(BLOCK)) ? DONE : FETCH;
            end
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Read data lands one cycle after the strobe, so the slot index is
    // delayed alongside a capture flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            words_q    <= '0;
            rem        <= '0;
            rd_cnt     <= '0;
            rd_idx     <= '0;
            cap_valid  <= 1'b0;
            cap_slot   <= '0;
            burst_addr <= '0;
        end else begin
            state     <= next_state;
            cap_valid <= rd_fire;
            cap_slot  <= rd_cnt[SLOT_W-1:0];
            if (accept) begin
                words_q    <= words_in;
                rem        <= words_in;
                rd_cnt     <= '0;
                rd_idx     <= '0;
                burst_addr <= base_addr;
            end else if (handshake) begin
                rem        <= rem - WORDS_W'(burst_n);
                rd_cnt     <= '0;
                burst_addr <= burst_addr + ADDR_W'(BLOCK);
            end else if (rd_fire) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
                rd_idx <= rd_idx + RD_W'(1);
            end
        end
    end

    block_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept || handshake),
        .wr_en   (cap_valid),
        .slot    (cap_slot),
        .wr_data (src_rd_data),
        .count   (burst_n),
        .data    (pack_data),
        .mask    (dma_wr_mask)
    );

endmodule

// File: tb/tb_store_block.sv
// Scoreboard bench for store_block: expected bursts are queued at start
// and popped on every DMA handshake.
module tb_store_block;
    import cnn_mem_pkg::*;

    typedef struct {
        logic [15:0]  addr;
        logic [399:0] data;
        logic [24:0]  mask;
    } burst_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  size;
    logic [15:0]  base_addr;
    logic         busy, done, src_rd_en;
    logic [9:0]   src_rd_addr;
    logic [15:0]  src_rd_data;
    logic         dma_wr_valid, dma_wr_ready;
    logic [15:0]  dma_wr_addr;
    logic [399:0] dma_wr_data;
    logic [24:0]  dma_wr_mask;

    logic [15:0]  mem [1024];
    burst_t       sb [$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rd_seen, valid_seen, hs_seen, done_seen, first_valid_rel, done_rel;

    logic         stalled_prev = 1'b0;
    logic [15:0]  held_addr;
    logic [399:0] held_data;
    logic [24:0]  held_mask;

    store_block dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .size         (size),
        .base_addr    (base_addr),
        .busy         (busy),
        .done         (done),
        .src_rd_en    (src_rd_en),
        .src_rd_addr  (src_rd_addr),
        .src_rd_data  (src_rd_data),
        .dma_wr_valid (dma_wr_valid),
        .dma_wr_ready (dma_wr_ready),
        .dma_wr_addr  (dma_wr_addr),
        .dma_wr_data  (dma_wr_data),
        .dma_wr_mask  (dma_wr_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (src_rd_en) src_rd_data <= mem[src_rd_addr];
    end

    task automatic check(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, src_rd_en, 0);
        check({tag, "_rd_addr"}, src_rd_addr, 0);
        check({tag, "_valid"}, dma_wr_valid, 0);
        check({tag, "_addr"}, dma_wr_addr, 0);
        check({tag, "_data"}, dma_wr_data, 0);
        check({tag, "_mask"}, dma_wr_mask, 0);
    endtask

    // Output monitor: event counting, hold-stability while stalled, scoreboard pops.
    always @(negedge clk) begin
        burst_t e;
        if (reset) begin
            stalled_prev = 1'b0;
        end else begin
            if (src_rd_en) rd_seen++;
            if (dma_wr_valid) begin
                valid_seen++;
                if (first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
            end
            if (stalled_prev && dma_wr_valid) begin
                check("stall_addr_stable", dma_wr_addr, held_addr);
                check("stall_data_stable", dma_wr_data, held_data);
                check("stall_mask_stable", dma_wr_mask, held_mask);
            end
            stalled_prev = dma_wr_valid && !dma_wr_ready;
            held_addr = dma_wr_addr;
            held_data = dma_wr_data;
            held_mask = dma_wr_mask;
            if (dma_wr_valid && dma_wr_ready) begin
                hs_seen++;
                check("burst_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("burst_addr", dma_wr_addr, e.addr);
                    check("burst_data", dma_wr_data, e.data);
                    check("burst_mask", dma_wr_mask, e.mask);
                end
            end
            if (done) begin
                done_seen++;
                done_rel = cyc - start_cyc;
                check("busy_low_at_done", busy, 0);
            end
        end
    end

    function automatic int push_expected(input int sz, input logic [15:0] base);
        int words, n, nb;
        burst_t e;
        words = (sz * sz > 1024) ? 1024 : sz * sz;
        nb = 0;
        for (int k = 0; k * 25 < words; k++) begin
            n = (words - k * 25 > 25) ? 25 : words - k * 25;
            e.addr = base + 16'(25 * k);
            e.data = '0;
            e.mask = '0;
            for (int j = 0; j < n; j++) begin
                e.data[j*16 +: 16] = mem[k * 25 + j];
                e.mask[j] = 1'b1;
            end
            sb.push_back(e);
            nb++;
        end
        return nb;
    endfunction

    task automatic clear_counts();
        rd_seen = 0; valid_seen = 0; hs_seen = 0; done_seen = 0;
        first_valid_rel = -1; done_rel = -1;
    endtask

    task automatic run_case(input int sz, input logic [15:0] base, input int stall,
                            input int exp_valid_rel, input int exp_done_rel);
        int words, nb, stall_cnt;
        words = (sz * sz > 1024) ? 1024 : sz * sz;
        nb = push_expected(sz, base);
        clear_counts();
        stall_cnt = 0;
        dma_wr_ready = (stall == 0);
        @(posedge clk); #1;
        start = 1'b1; size = 16'(sz); base_addr = base; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; size = 16'd3; base_addr = 16'hDEAD;
        check("busy_after_start", busy, 1);
        @(posedge clk); #1;
        start = 1'b1; size = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 3000 && done_seen == 0; t++) begin
            if (done) begin
                start = 1'b1; size = 16'd5;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (stall > 0) begin
                if (dma_wr_valid) begin
                    stall_cnt++;
                    dma_wr_ready = (stall_cnt > stall);
                end else begin
                    stall_cnt = 0;
                    dma_wr_ready = 1'b0;
                end
            end
        end
        dma_wr_ready = 1'b1;
        check("done_within_budget", done_seen != 0, 1);
        repeat (2) @(posedge clk);
        #1;
        check("start_ignored_idle_after", busy, 0);
        check("done_count", done_seen, 1);
        check("read_count", rd_seen, words);
        check("handshake_count", hs_seen, nb);
        check("valid_cycles", valid_seen, nb * (stall + 1));
        check("scoreboard_empty", sb.size(), 0);
        if (exp_valid_rel >= 0) check("first_valid_cycle", first_valid_rel, exp_valid_rel);
        if (exp_done_rel >= 0) check("done_cycle", done_rel, exp_done_rel);
        sb.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; size = '0; base_addr = '0; dma_wr_ready = 1'b1;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        $display("[TB] size=5 single burst");
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        run_case(5, 16'h0100, 0, 27, 28);

        $display("[TB] size=7 negative ramp, two bursts");
        for (int i = 0; i < 1024; i++) mem[i] = 16'(-i);
        run_case(7, 16'h0000, 0, -1, -1);

        $display("[TB] size=0 empty store");
        run_case(0, 16'h1234, 0, -1, 2);

        $display("[TB] size=5 with ready stall");
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 5 + 1);
        run_case(5, 16'h0200, 3, -1, -1);

        $display("[TB] size=10 reset mid-write");
        for (int i = 0; i < 1024; i++) mem[i] = 16'(1000 - i);
        void'(push_expected(10, 16'h0300));
        clear_counts();
        dma_wr_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; size = 16'd10; base_addr = 16'h0300; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 500 && !(hs_seen >= 1 && dma_wr_valid); t++) begin
            @(posedge clk); #1;
        end
        check("second_burst_reached", (hs_seen == 1) && dma_wr_valid, 1);
        reset = 1'b1;
        dma_wr_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("abort");
        @(posedge clk); #1;
        reset = 1'b0;
        dma_wr_ready = 1'b1;
        check("abort_pending_bursts", sb.size(), 3);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_seen, 0);
        sb.delete();
        run_case(10, 16'h0300, 0, -1, -1);

        $display("[TB] size=8 address wrap");
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i ^ 16'h5A5A);
        run_case(8, 16'hFFF0, 0, -1, -1);

        $display("[TB] size=40 clamp to buffer depth");
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 37 + 5);
        run_case(40, 16'h0000, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
